bf_decoder: RTL
===============

# bf_decoder

- Executes the Brainfuck instruction stream for the bf-cpu core.
- Accepts ASCII instruction bytes from the fetch stage over a valid/ready handshake and keeps the data pointer.
- Performs read-modify-write of tape cells through the existing `alu` (nochange/decrement/increment).
- Handles forward loop skipping and requests backward jumps from fetch; sits between fetch and the tape RAM.

## Interface
- ADDR_W, 8, tape address width; the pointer wraps modulo 2^ADDR_W
- DEPTH_W, 8, width of the loop-skip nesting counter
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- inst_valid  in  1  fetch offers an instruction
- inst_data  in  8  ASCII instruction byte
- inst_ready  out  1  decoder accepts; transfer when valid && ready
- jump_back  out  1  one-cycle pulse: `]` with nonzero cell; fetch rewinds to the matching `[`
- skipping  out  1  high while discarding instructions after `[` on a zero cell
- err  out  1  sticky; skip depth overflow; cleared only by rst
- tape_addr  out  ADDR_W  always equals ptr
- tape_rdata  in  8  registered RAM read, 1-cycle latency from tape_addr
- tape_wdata  out  8  write data
- tape_we  out  1  write enable
- out_valid / out_data[8] / out_ready  out/out/in  `.` output port (BF_DECODER_IO_EN)
- in_valid / in_data[8] / in_ready  in/in/out  `,` input port (BF_DECODER_IO_EN)

## Operation
- States: IDLE, READ, EXEC, OUT, IN, SKIP.
- IDLE: inst_ready=1.
  - `>` / `<`: ptr ±1 with wrap (0xFF..→0, 0→max); stay in IDLE.
  - Non-command bytes: consumed in one cycle, no effect.
  - `+ - [ ] . ,`: latch the opcode and go to READ.
- READ: inst_ready=0; tape_addr=ptr settles; go to EXEC.
- EXEC: tape_rdata valid and feeds `alu.a`.
  - `+`: increment=1.
  - `-`: decrement=1.
  - Otherwise nochange=1; the select is always one-hot.
  - `+` / `-`: tape_we=1, tape_wdata=alu.out (8-bit wrap: 0xFF+1=0x00, 0x00-1=0xFF); go to IDLE.
  - `[`: cell==0 → depth=1, SKIP; else IDLE.
  - `]`: cell!=0 → jump_back=1; IDLE in both cases.
  - `.`: latch cell into out_data; go to OUT.
  - `,`: go to IN.
- OUT: out_valid=1 until out_ready; then IDLE.
- IN: in_ready=1; on in_valid, tape_we=1, tape_wdata=in_data; then IDLE.
- SKIP: inst_ready=1, skipping=1.
  - `[`: depth+1. If depth is already all-ones, set err, hold depth, stay in SKIP.
  - `]`: depth-1; reaching 0 → IDLE.
  - All other bytes are discarded.
- Reset values: state=IDLE, ptr=0, depth=0, err=0, jump_back=0, tape_we=0, out_valid=0, in_ready=0, skipping=0, inst_ready=1 (combinational from IDLE), out_data=0, tape_wdata=0.
- Reset mid-operation: abandons any pending write or I/O immediately (asynchronous); tape_we drops without waiting for a clock.

## Timing
- Pointer op: accepted at edge N; ptr updated at N; the next instruction can be accepted at edge N+1.
- `+` / `-` / `[` / `]`: accepted at edge N; READ in cycle N+1; EXEC in cycle N+2 with tape_we/jump_back; IDLE in cycle N+3. Throughput is 1 per 3 cycles.
- `.`: out_valid first high in cycle N+3; each stall cycle adds one.
- `,`: in_ready first high in cycle N+3; write occurs in the handshake cycle.
- jump_back is exactly one cycle wide. Fetch must not present the rewound instruction before the cycle after the pulse.

## Configuration
- BF_DECODER_IO_EN defined: `.` and `,` execute as above and the out_* / in_* ports exist.
- Undefined: those ports are absent, OUT and IN states are removed, and `.` / `,` are one-cycle no-ops in IDLE (no READ).

## Structure
- Package `bf_pkg`:
  - state enum `bf_state_t`
  - ASCII constants BF_INC, BF_DEC, BF_RIGHT, BF_LEFT, BF_OUT, BF_IN, BF_LOOP, BF_END
  - `bf_op_t` latched-opcode typedef
- One sub-module: the existing `alu`, instantiated once. `a` = tape_rdata; selects come from the EXEC decode.

## Test plan
- Reset, then `+` `+` `+` on cell 0 (0x00) → three tape_we pulses with wdata 0x01, 0x02, 0x03, each in cycle N+2 of its accept.
- `-` on cell 0x00 → wdata 0xFF. Then `<` from ptr 0 → tape_addr = 2^ADDR_W−1.
- Cell 0 = 0, stream `[ + [ - ] > ] +` → skipping high through the matching `]`; no writes during skip; final `+` writes 0x01 at ptr 0.
- Cell = 0x05, `]` → jump_back is a single one-cycle pulse and no write occurs. With cell 0x00, `]` → no pulse.
- (IO_EN) Cell 0x41, `.` with out_ready held low 4 cycles → out_valid held with data 0x41, released after the handshake. `,` with in_data 0x7A → cell written 0x7A.
- Assert rst during EXEC of `+` → tape_we drops immediately; ptr=0, state=IDLE, err=0 after release.

Source files
------------

// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared types and ASCII opcode constants for the bf-cpu decoder
package bf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_EXEC = 3'd2,
      ST_OUT  = 3'd3,
      ST_IN   = 3'd4,
      ST_SKIP = 3'd5
   } bf_state_t;

   localparam logic [7:0] BF_INC   = 8'h2B;  // +
   localparam logic [7:0] BF_DEC   = 8'h2D;  // -
   localparam logic [7:0] BF_RIGHT = 8'h3E;  // >
   localparam logic [7:0] BF_LEFT  = 8'h3C;  // <
   localparam logic [7:0] BF_OUT   = 8'h2E;  // .
   localparam logic [7:0] BF_IN    = 8'h2C;  // ,
   localparam logic [7:0] BF_LOOP  = 8'h5B;  // [
   localparam logic [7:0] BF_END   = 8'h5D;  // ]

   typedef enum logic [2:0] {
      OP_INC  = 3'd0,
      OP_DEC  = 3'd1,
      OP_LOOP = 3'd2,
      OP_END  = 3'd3,
      OP_OUT  = 3'd4,
      OP_IN   = 3'd5
   } bf_op_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - cell arithmetic unit: pass, decrement or increment an 8-bit value
module alu (
   input  logic [7:0] a,
   input  logic       nochange,
   input  logic       decrement,
   input  logic       increment,
   output logic [7:0] out
);

   // one-hot select; any other pattern passes the operand through
   always_comb begin
      out = a;
      case ({increment, decrement, nochange})
         3'b100:  out = a + 8'd1;
         3'b010:  out = a - 8'd1;
         default: out = a;
      endcase
   end

endmodule

// File: rtl/bf_decoder.sv
// rtl/bf_decoder.sv - Brainfuck execute stage; BF_DECODER_IO_EN adds the . and , ports
module bf_decoder
   import bf_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DEPTH_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_valid,
   input  logic [7:0]        inst_data,
   output logic              inst_ready,
   output logic              jump_back,
   output logic              skipping,
   output logic              err,
   output logic [ADDR_W-1:0] tape_addr,
   input  logic [7:0]        tape_rdata,
   output logic [7:0]        tape_wdata,
   output logic              tape_we
`ifdef BF_DECODER_IO_EN
   ,
   output logic              out_valid,
   output logic [7:0]        out_data,
   input  logic              out_ready,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready
`endif
);

   bf_state_t          state_q, state_d;
   bf_op_t             op_q, op_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               err_q, err_d;
   logic [7:0]         alu_out;
   logic               sel_inc, sel_dec, sel_nochange;
`ifdef BF_DECODER_IO_EN
   logic [7:0]         out_data_q, out_data_d;
`endif

   // alu selects are decoded from the latched opcode only while the cell is on tape_rdata
   assign sel_inc      = (state_q == ST_EXEC) && (op_q == OP_INC);
   assign sel_dec      = (state_q == ST_EXEC) && (op_q == OP_DEC);
   assign sel_nochange = !(sel_inc || sel_dec);

   alu u_alu (
      .a         (tape_rdata),
      .nochange  (sel_nochange),
      .decrement (sel_dec),
      .increment (sel_inc),
      .out       (alu_out)
   );

   assign tape_addr = ptr_q;
   assign err       = err_q;
`ifdef BF_DECODER_IO_EN
   assign out_data  = out_data_q;
   assign out_valid = (state_q == ST_OUT);
   assign in_ready  = (state_q == ST_IN);
`endif

   // next-state and strobe decode; strobes are combinational from state so reset kills them at once
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      ptr_d      = ptr_q;
      depth_d    = depth_q;
      err_d      = err_q;
      inst_ready = 1'b0;
      skipping   = 1'b0;
      jump_back  = 1'b0;
      tape_we    = 1'b0;
      tape_wdata = 8'h00;
`ifdef BF_DECODER_IO_EN
      out_data_d = out_data_q;
`endif
      case (state_q)
         ST_IDLE: begin
            inst_ready = 1'b1;
            if (inst_valid) begin
               case (inst_data)
                  BF_RIGHT: ptr_d = ptr_q + ADDR_W'(1);
                  BF_LEFT:  ptr_d = ptr_q - ADDR_W'(1);
                  BF_INC:   begin op_d = OP_INC;  state_d = ST_READ; end
                  BF_DEC:   begin op_d = OP_DEC;  state_d = ST_READ; end
                  BF_LOOP:  begin op_d = OP_LOOP; state_d = ST_READ; end
                  BF_END:   begin op_d = OP_END;  state_d = ST_READ; end
`ifdef BF_DECODER_IO_EN
                  BF_OUT:   begin op_d = OP_OUT;  state_d = ST_READ; end
                  BF_IN:    begin op_d = OP_IN;   state_d = ST_READ; end
`endif
                  default:  ;
               endcase
            end
         end
         ST_READ: begin
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_IDLE;
            case (op_q)
               OP_INC, OP_DEC: begin
                  tape_we    = 1'b1;
                  tape_wdata = alu_out;
               end
               OP_LOOP: begin
                  if (tape_rdata == 8'h00) begin
                     depth_d = DEPTH_W'(1);
                     state_d = ST_SKIP;
                  end
               end
               OP_END: begin
                  jump_back = (tape_rdata != 8'h00);
               end
`ifdef BF_DECODER_IO_EN
               OP_OUT: begin
                  out_data_d = tape_rdata;
                  state_d    = ST_OUT;
               end
               OP_IN: begin
                  state_d = ST_IN;
               end
`endif
               default: ;
            endcase
         end
`ifdef BF_DECODER_IO_EN
         ST_OUT: begin
            if (out_ready) state_d = ST_IDLE;
         end
         ST_IN: begin
            if (in_valid) begin
               tape_we    = 1'b1;
               tape_wdata = in_data;
               state_d    = ST_IDLE;
            end
         end
`endif
         ST_SKIP: begin
            inst_ready = 1'b1;
            skipping   = 1'b1;
            if (inst_valid) begin
               if (inst_data == BF_LOOP) begin
                  // saturate rather than wrap so a later ] cannot exit the skip early
                  if (&depth_q) err_d = 1'b1;
                  else          depth_d = depth_q + DEPTH_W'(1);
               end else if (inst_data == BF_END) begin
                  depth_d = depth_q - DEPTH_W'(1);
                  if (depth_q == DEPTH_W'(1)) state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // architectural state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_INC;
         ptr_q   <= '0;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ptr_q   <= ptr_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

`ifdef BF_DECODER_IO_EN
   // holds the cell value presented on the output port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) out_data_q <= 8'h00;
      else     out_data_q <= out_data_d;
   end
`endif

endmodule
